// File: rtl/load_align_unit_pkg.sv
// Shared load op codes, FSM state encoding and small decode helpers for the
// load alignment unit.
package load_align_unit_pkg;

  typedef enum logic [2:0] {
    LD_LB  = 3'd0,
    LD_LBU = 3'd1,
    LD_LH  = 3'd2,
    LD_LHU = 3'd3,
    LD_LW  = 3'd4,
    LD_LWL = 3'd5,
    LD_LWR = 3'd6,
    LD_RSV = 3'd7
  } ld_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_RESP = 3'd3,
    ST_ERR  = 3'd4
  } ld_state_e;

  // Reserved op, and LWL/LWR when unsupported, collapse onto plain LW.
  function automatic ld_op_e norm_op(input logic [2:0] op, input logic lwlr_en);
    ld_op_e o;
    o = ld_op_e'(op);
    if (o == LD_RSV) return LD_LW;
    if (!lwlr_en && (o == LD_LWL || o == LD_LWR)) return LD_LW;
    return o;
  endfunction

  function automatic logic misaligned(input ld_op_e op, input logic [1:0] off);
    case (op)
      LD_LH, LD_LHU: return off[0];
      LD_LW:         return (off != 2'b00);
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Combinational lane select, sign/zero extension and LWL/LWR merge of a
// little-endian memory word into a GPR write value.
module load_align_ext
  import load_align_unit_pkg::*;
(
  input  ld_op_e      op,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  input  logic [31:0] rt_old,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[8*off +: 8];
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    data     = rdata;
    case (op)
      LD_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU: data = {24'd0, byte_sel};
      LD_LH:  data = {{16{half_sel[15]}}, half_sel};
      LD_LHU: data = {16'd0, half_sel};
      // LWL fills the upper bytes of rt from memory, LWR fills the lower ones.
      LD_LWL: begin
        case (off)
          2'd0:    data = {rdata[7:0],  rt_old[23:0]};
          2'd1:    data = {rdata[15:0], rt_old[15:0]};
          2'd2:    data = {rdata[23:0], rt_old[7:0]};
          default: data = rdata;
        endcase
      end
      LD_LWR: begin
        case (off)
          2'd0:    data = rdata;
          2'd1:    data = {rt_old[31:24], rdata[31:8]};
          2'd2:    data = {rt_old[31:16], rdata[31:16]};
          default: data = {rt_old[31:8],  rdata[31:24]};
        endcase
      end
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// Single-outstanding load unit: word-aligned read request, response wait with
// optional timeout, then aligned/extended result or address-error report.
module load_align_unit
  import load_align_unit_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter bit LWLR_EN     = 1'b1,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [2:0]        ld_op,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_rt_old,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              res_valid,
  output logic [31:0]       res_data,
  output logic              res_adel,
  output logic              res_buserr,
  output logic [ADDR_W-1:0] res_badva
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYC);

  ld_state_e         state_q, state_d;
  logic              ld_ready_q, ld_ready_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              res_valid_q, res_valid_d;
  logic [31:0]       res_data_q, res_data_d;
  logic              res_adel_q, res_adel_d;
  logic              res_buserr_q, res_buserr_d;
  logic [ADDR_W-1:0] res_badva_q, res_badva_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  ld_op_e            op_q, op_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       rt_q, rt_d;
  ld_op_e            acc_op;
  logic [31:0]       ext_data;

  load_align_ext u_ext (
    .op     (op_q),
    .off    (off_q),
    .rdata  (mem_rdata),
    .rt_old (rt_q),
    .data   (ext_data)
  );

  always_comb begin
    state_d      = state_q;
    ld_ready_d   = ld_ready_q;
    mem_req_d    = 1'b0;
    mem_addr_d   = mem_addr_q;
    res_valid_d  = 1'b0;
    res_data_d   = res_data_q;
    res_adel_d   = res_adel_q;
    res_buserr_d = res_buserr_q;
    res_badva_d  = res_badva_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    off_d        = off_q;
    rt_d         = rt_q;
    acc_op       = norm_op(ld_op, LWLR_EN);
    case (state_q)
      ST_IDLE: begin
        if (ld_valid && ld_ready_q) begin
          op_d       = acc_op;
          off_d      = ld_addr[1:0];
          rt_d       = ld_rt_old;
          ld_ready_d = 1'b0;
          if (misaligned(acc_op, ld_addr[1:0])) begin
            state_d      = ST_ERR;
            res_valid_d  = 1'b1;
            res_adel_d   = 1'b1;
            res_buserr_d = 1'b0;
            res_data_d   = 32'd0;
            res_badva_d  = ld_addr;
          end else begin
            state_d    = ST_REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = {ld_addr[ADDR_W-1:2], 2'b00};
          end
        end
      end
      ST_REQ: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        // A response arriving on the last allowed cycle still wins over timeout.
        if (mem_rvalid) begin
          state_d      = ST_RESP;
          res_valid_d  = 1'b1;
          res_data_d   = ext_data;
          res_adel_d   = 1'b0;
          res_buserr_d = 1'b0;
        end else if ((TIMEOUT_CYC > 0) && (cnt_q + CNT_W'(1) == TMO)) begin
          state_d      = ST_RESP;
          res_valid_d  = 1'b1;
          res_data_d   = 32'd0;
          res_adel_d   = 1'b0;
          res_buserr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP, ST_ERR: begin
        state_d    = ST_IDLE;
        ld_ready_d = 1'b1;
      end
      default: begin
        state_d    = ST_IDLE;
        ld_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ld_ready_q   <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= 32'd0;
      res_adel_q   <= 1'b0;
      res_buserr_q <= 1'b0;
      res_badva_q  <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      ld_ready_q   <= ld_ready_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_adel_q   <= res_adel_d;
      res_buserr_q <= res_buserr_d;
      res_badva_q  <= res_badva_d;
      cnt_q        <= cnt_d;
    end
  end

  // Request context only matters while a load is in flight; no reset needed.
  always_ff @(posedge clk) begin
    op_q  <= op_d;
    off_q <= off_d;
    rt_q  <= rt_d;
  end

  assign ld_ready   = ld_ready_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_adel   = res_adel_q;
  assign res_buserr = res_buserr_q;
  assign res_badva  = res_badva_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboard bench for load_align_unit: directed and random loads against a
// byte-arithmetic reference model, with a decoupled result monitor.
module tb_load_align_unit;

  localparam int TMO = 4;

  logic        clk;
  logic        rst;
  logic        ld_valid;
  logic        ld_ready;
  logic [2:0]  ld_op;
  logic [31:0] ld_addr;
  logic [31:0] ld_rt_old;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_adel;
  logic        res_buserr;
  logic [31:0] res_badva;

  load_align_unit #(.ADDR_W(32), .LWLR_EN(1'b1), .TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_op      (ld_op),
    .ld_addr    (ld_addr),
    .ld_rt_old  (ld_rt_old),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_adel   (res_adel),
    .res_buserr (res_buserr),
    .res_badva  (res_badva)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        adel;
    logic        buserr;
    logic [31:0] badva;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   mem_req_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: memory bytes taken as plain numbers, merged by shift and mask.
  function automatic exp_t model(input int op_in, input logic [31:0] addr,
                                 input logic [31:0] rt, input logic [31:0] m,
                                 input bit timeout);
    exp_t        e;
    int          op;
    int          off;
    int          b;
    int          h;
    logic [31:0] mask;
    op       = (op_in == 7) ? 4 : op_in;
    off      = int'(addr[1:0]);
    e.data   = 32'd0;
    e.adel   = 1'b0;
    e.buserr = 1'b0;
    e.badva  = addr;
    if (((op == 2 || op == 3) && (off % 2 != 0)) || (op == 4 && off != 0)) begin
      e.adel = 1'b1;
      return e;
    end
    if (timeout) begin
      e.buserr = 1'b1;
      return e;
    end
    b = int'((m >> (8 * off)) & 32'hFF);
    h = int'((m >> (16 * (off / 2))) & 32'hFFFF);
    case (op)
      0: e.data = (b > 127) ? 32'(b - 256) : 32'(b);
      1: e.data = 32'(b);
      2: e.data = (h > 32767) ? 32'(h - 65536) : 32'(h);
      3: e.data = 32'(h);
      5: begin
        mask   = (32'h1 << (8 * (3 - off))) - 32'h1;
        e.data = (m << (8 * (3 - off))) | (rt & mask);
      end
      6: begin
        mask   = 32'hFFFF_FFFF >> (8 * off);
        e.data = (m >> (8 * off)) | (rt & ~mask);
      end
      default: e.data = m;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mem_req === 1'b1) mem_req_cnt++;
    if (res_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_res_valid: got res_valid=1 data=%h, expected no result", res_data);
      end else begin
        e = sb.pop_front();
        chk("res_data", res_data, e.data);
        chk("res_adel", {31'd0, res_adel}, {31'd0, e.adel});
        chk("res_buserr", {31'd0, res_buserr}, {31'd0, e.buserr});
        if (e.adel) chk("res_badva", res_badva, e.badva);
      end
    end
  end

  task automatic wait_ready();
    int t;
    t = 0;
    while (ld_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (ld_ready !== 1'b1) chk("ld_ready_timeout", {31'd0, ld_ready}, 32'd1);
  endtask

  // One complete load; lat = WAIT cycle (1-based) carrying rvalid.
  task automatic do_load(input int op, input logic [31:0] addr, input logic [31:0] rt,
                         input logic [31:0] m, input int lat, input bit spur,
                         input bit no_resp);
    exp_t e;
    e = model(op, addr, rt, m, no_resp);
    wait_ready();
    sb.push_back(e);
    ld_valid  = 1'b1;
    ld_op     = 3'(op);
    ld_addr   = addr;
    ld_rt_old = rt;
    @(negedge clk);
    ld_valid  = 1'b0;
    ld_op     = 3'($urandom);
    ld_addr   = $urandom;
    ld_rt_old = $urandom;
    if (e.adel) begin
      chk("err_latency", {31'd0, res_valid}, 32'd1);
      chk("err_no_mem_req", {31'd0, mem_req}, 32'd0);
      return;
    end
    chk("mem_req_asserted", {31'd0, mem_req}, 32'd1);
    chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
    if (spur) begin
      mem_rvalid = 1'b1;
      mem_rdata  = ~m;
    end
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("mem_req_one_cycle", {31'd0, mem_req}, 32'd0);
    if (no_resp) begin
      repeat (TMO) @(negedge clk);
      chk("timeout_latency", {31'd0, res_valid}, 32'd1);
      @(negedge clk);
      mem_rvalid = 1'b1;
      mem_rdata  = m;
      @(negedge clk);
      mem_rvalid = 1'b0;
      return;
    end
    repeat (lat - 1) @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = m;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    chk("resp_latency", {31'd0, res_valid}, 32'd1);
  endtask

  initial begin : stim
    int c0;
    int t;
    rst        = 1'b1;
    ld_valid   = 1'b0;
    ld_op      = 3'd0;
    ld_addr    = 32'd0;
    ld_rt_old  = 32'd0;
    mem_rdata  = 32'd0;
    mem_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_adel", {31'd0, res_adel}, 32'd0);
    chk("rst_res_buserr", {31'd0, res_buserr}, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_badva", res_badva, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_load(0, 32'h13, 32'h0BAD_F00D, 32'h80FF_7F01, 1, 1'b0, 1'b0);
    do_load(1, 32'h13, 32'h0BAD_F00D, 32'h80FF_7F01, 2, 1'b0, 1'b0);
    do_load(2, 32'h22, 32'h0BAD_F00D, 32'h8001_1234, 1, 1'b1, 1'b0);
    do_load(3, 32'h22, 32'h0BAD_F00D, 32'h8001_1234, 3, 1'b0, 1'b0);
    do_load(4, 32'h20, 32'h0BAD_F00D, 32'hDEAD_BEEF, 1, 1'b1, 1'b0);
    do_load(5, 32'h41, 32'hAABB_CCDD, 32'h1122_3344, 1, 1'b0, 1'b0);
    do_load(6, 32'h41, 32'hAABB_CCDD, 32'h1122_3344, 2, 1'b0, 1'b0);
    do_load(7, 32'h44, 32'h0, 32'hCAFE_0001, 1, 1'b0, 1'b0);

    c0 = mem_req_cnt;
    do_load(2, 32'h03, 32'h1234_5678, 32'h0, 1, 1'b0, 1'b0);
    do_load(4, 32'h22, 32'h1234_5678, 32'h0, 1, 1'b0, 1'b0);
    do_load(7, 32'h101, 32'h1234_5678, 32'h0, 1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("adel_mem_req_count", 32'(mem_req_cnt), 32'(c0));

    do_load(4, 32'h100, 32'h0, 32'h5555_AAAA, 1, 1'b0, 1'b1);
    do_load(0, 32'h102, 32'h0, 32'h0077_0000, 1, 1'b0, 1'b0);

    wait_ready();
    ld_valid  = 1'b1;
    ld_op     = 3'd4;
    ld_addr   = 32'h200;
    ld_rt_old = 32'h0;
    @(negedge clk);
    ld_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ld_ready", {31'd0, ld_ready}, 32'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    do_load(3, 32'h202, 32'h0, 32'hBEEF_0000, 1, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_load(int'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
              int'($urandom_range(1, 3)), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 19) == 0));
    end

    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
